// File: rtl/psum_feeder_pkg.sv
// Shared sizing and state encoding for the partial-sum feeder.
// No logic; constants only.
// Not applicable.
package psum_feeder_pkg;

    localparam int DWd    = 16;
    localparam int NPix   = 16;
    localparam int PassWd = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } psum_feed_state_e;

endpackage

// File: rtl/psum_feeder_rf.sv
// Per-pixel partial-sum storage: combinational read, registered write.
// Read 0 cycles, write visible the cycle after wr_vld.
// None; always accepts writes.
module psum_feeder_rf #(
    parameter  int DWd   = 16,
    parameter  int NPix  = 16,
    localparam int IdxWd = $clog2(NPix)
) (
    input  logic                  core_clk,
    input  logic                  wr_vld,
    input  logic [IdxWd-1:0]      wr_idx,
    input  logic signed [DWd-1:0] wr_dat,
    input  logic [IdxWd-1:0]      rd_idx,
    output logic signed [DWd-1:0] rd_dat
);

    logic signed [DWd-1:0] mem [NPix];

    always_ff @(posedge core_clk) begin
        if (wr_vld) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/psum_feeder.sv
// Feeds stored partial sums to the sum stage and banks/forwards its returns.
// Feed and result paths are combinational off registered state; done one cycle after last return.
// Feed valid ignores ready; return ready follows result ready on the final pass.
module psum_feeder
    import psum_feeder_pkg::*;
#(
    parameter  int DWd    = psum_feeder_pkg::DWd,
    parameter  int NPix   = psum_feeder_pkg::NPix,
    parameter  int PassWd = psum_feeder_pkg::PassWd,
    localparam int IdxWd  = $clog2(NPix),
    localparam int OutWd  = IdxWd + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [PassWd-1:0]     i_npass,
    output logic                  o_busy,
    output logic                  o_done,
    output logic signed [DWd-1:0] o_psum,
    output logic                  o_psum_valid,
    input  logic                  i_psum_ready,
    output logic                  o_first_pix,
    input  logic signed [DWd-1:0] i_ret,
    input  logic                  i_ret_valid,
    output logic                  o_ret_ready,
    output logic signed [DWd-1:0] o_res,
    output logic                  o_res_valid,
    input  logic                  i_res_ready
);

    psum_feed_state_e      state;
    logic [PassWd-1:0]     npass_q;
    logic [IdxWd-1:0]      feed_idx;
    logic [PassWd-1:0]     feed_pass;
    logic [IdxWd-1:0]      ret_idx;
    logic [PassWd-1:0]     ret_pass;
    logic [OutWd-1:0]      outstanding;

    logic                  run;
    logic                  final_pass;
    logic                  feed_fire;
    logic                  ret_fire;
    logic signed [DWd-1:0] rf_rd_dat;

    assign run        = (state == RUN);
    assign final_pass = (ret_pass == npass_q - PassWd'(1));

    // Capping outstanding at NPix keeps every pass-(p+1) read behind its pass-p write.
    assign o_psum_valid = run && (feed_pass < npass_q) && (outstanding < OutWd'(NPix));
    assign feed_fire    = o_psum_valid && i_psum_ready;
    assign o_first_pix  = o_psum_valid && (feed_idx == '0);
    assign o_psum       = (run && feed_pass != '0) ? rf_rd_dat : '0;

    assign o_ret_ready  = run && (!final_pass || i_res_ready);
    assign ret_fire     = i_ret_valid && o_ret_ready;
    assign o_res_valid  = run && final_pass && i_ret_valid;
    assign o_res        = (run && final_pass) ? i_ret : '0;

    assign o_busy = (state != IDLE);
    assign o_done = (state == DONE);

    psum_feeder_rf #(
        .DWd  (DWd),
        .NPix (NPix)
    ) u_rf (
        .core_clk (i_clk),
        .wr_vld   (ret_fire && !final_pass),
        .wr_idx   (ret_idx),
        .wr_dat   (i_ret),
        .rd_idx   (feed_idx),
        .rd_dat   (rf_rd_dat)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state       <= IDLE;
            npass_q     <= '0;
            feed_idx    <= '0;
            feed_pass   <= '0;
            ret_idx     <= '0;
            ret_pass    <= '0;
            outstanding <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        npass_q     <= i_npass;
                        feed_idx    <= '0;
                        feed_pass   <= '0;
                        ret_idx     <= '0;
                        ret_pass    <= '0;
                        outstanding <= '0;
                        state       <= (i_npass == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (feed_fire) begin
                        if (feed_idx == IdxWd'(NPix - 1)) begin
                            feed_idx  <= '0;
                            feed_pass <= feed_pass + PassWd'(1);
                        end else begin
                            feed_idx  <= feed_idx + IdxWd'(1);
                        end
                    end
                    if (ret_fire) begin
                        if (ret_idx == IdxWd'(NPix - 1)) begin
                            ret_idx  <= '0;
                            ret_pass <= ret_pass + PassWd'(1);
                            if (final_pass) begin
                                state <= DONE;
                            end
                        end else begin
                            ret_idx  <= ret_idx + IdxWd'(1);
                        end
                    end
                    case ({feed_fire, ret_fire})
                        2'b10:   outstanding <= outstanding + OutWd'(1);
                        2'b01:   outstanding <= outstanding - OutWd'(1);
                        default: outstanding <= outstanding;
                    endcase
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
